// File: rtl/evenodd_stream_classifier.sv
// evenodd_stream_classifier
// Tags each accepted word as even or odd under a selectable mode and forwards
// it through one output register stage with a valid/ready handshake. It also
// keeps saturating per-class counters and flags runs of same-class words
// accepted under an unchanged mode.
module evenodd_stream_classifier #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  parameter int RUN_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              even,
  output logic              odd,
  output logic              run_hit,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt
);

  // Run length only needs to count up to RUN_LEN; it saturates there.
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_EVEN = 2'd1,
    RUN_ODD  = 2'd2
  } run_state_t;

  run_state_t       r_state;
  run_state_t       w_state_next;
  logic [RW-1:0]    r_run_cnt;
  logic [RW-1:0]    w_run_cnt_next;
  logic [1:0]       r_prev_mode;
  logic             r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic             r_odd;
  logic             r_run_hit;
  logic [CNT_W-1:0] r_even_cnt;
  logic [CNT_W-1:0] r_odd_cnt;
  logic [CNT_W-1:0] w_even_cnt_next;
  logic [CNT_W-1:0] w_odd_cnt_next;
  logic             w_accept;
  logic             w_odd;
  logic             w_same_run;

  // Ready is withheld during reset so nothing is accepted into a stage being cleared.
  assign in_ready = !reset && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Classify the incoming word under the current mode; mode 11 falls back to LSB parity.
  always_comb begin
    w_odd = data_in[0];
    case (mode)
      2'b01:   w_odd = ^data_in;
      2'b10:   w_odd = |data_in[1:0];
      default: w_odd = data_in[0];
    endcase
  end

  // Run tracking next state: extend on same class and mode, otherwise restart at 1.
  always_comb begin
    w_state_next   = r_state;
    w_run_cnt_next = r_run_cnt;
    w_same_run     = ((r_state == RUN_ODD) && w_odd) || ((r_state == RUN_EVEN) && !w_odd);
    if (w_accept) begin
      if (w_same_run && (mode == r_prev_mode)) begin
        if (r_run_cnt != RUN_MAX) begin
          w_run_cnt_next = r_run_cnt + RW'(1);
        end
      end else begin
        w_state_next   = w_odd ? RUN_ODD : RUN_EVEN;
        w_run_cnt_next = RW'(1);
      end
    end
  end

  // Run state register; clr_cnt deliberately has no influence here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_run_cnt   <= '0;
      r_prev_mode <= 2'b00;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_cnt_next;
      if (w_accept) begin
        r_prev_mode <= mode;
      end
    end
  end

  // Output stage: load on accept, drop valid on a consume with no new word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_odd       <= 1'b0;
      r_run_hit   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= data_in;
      r_odd       <= w_odd;
      r_run_hit   <= (w_run_cnt_next >= RUN_MAX);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counter next values: clear first, then the accepted class counts from there.
  always_comb begin
    w_even_cnt_next = clr_cnt ? '0 : r_even_cnt;
    w_odd_cnt_next  = clr_cnt ? '0 : r_odd_cnt;
    if (w_accept) begin
      if (w_odd) begin
        if (w_odd_cnt_next != CNT_MAX) begin
          w_odd_cnt_next = w_odd_cnt_next + CNT_W'(1);
        end
      end else begin
        if (w_even_cnt_next != CNT_MAX) begin
          w_even_cnt_next = w_even_cnt_next + CNT_W'(1);
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_even_cnt <= '0;
      r_odd_cnt  <= '0;
    end else begin
      r_even_cnt <= w_even_cnt_next;
      r_odd_cnt  <= w_odd_cnt_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign odd       = r_odd;
  // Before the first beat both tags read 0, matching the reset state of the stage.
  assign even      = r_out_valid ? !r_odd : (r_state != IDLE) && !r_odd;
  assign run_hit   = r_run_hit;
  assign even_cnt  = r_even_cnt;
  assign odd_cnt   = r_odd_cnt;

endmodule

// File: tb/tb_evenodd_stream_classifier.sv
// Testbench for evenodd_stream_classifier: random and directed stimulus,
// a reference model that pushes expected beats into a scoreboard on accept,
// and a monitor that pops and compares on every consumed output beat.
module tb_evenodd_stream_classifier;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int RL = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          even;
  logic          odd;
  logic          run_hit;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] even_cnt;
  logic [CW-1:0] odd_cnt;

  evenodd_stream_classifier #(.DATA_W(DW), .CNT_W(CW), .RUN_LEN(RL)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .even(even), .odd(odd), .run_hit(run_hit), .clr_cnt(clr_cnt),
    .even_cnt(even_cnt), .odd_cnt(odd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          o;
    logic          h;
  } beat_t;

  beat_t      sb[$];
  logic [2:0] hist[$];
  int         total = 0;
  int         bad = 0;
  int         pops = 0;
  int         m_even = 0;
  int         m_odd = 0;
  logic [31:0] odd_bits = '0;
  logic [31:0] hit_bits = '0;
  int         ready_mode = 0;   // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Class rule written straight from the mode table.
  function automatic logic ref_odd(input logic [DW-1:0] d, input logic [1:0] m);
    if (m == 2'b01) return ($countones(d) % 2) == 1;
    if (m == 2'b10) return (d % 4) != 0;
    return (d % 2) == 1;
  endfunction

  // Downstream ready driver.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (ready_mode == 1);
  end

  // Reference model and monitor; everything here is sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      hist.delete();
      m_even = 0;
      m_odd = 0;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (out_valid && sb.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(sb[0].d));
        chk("odd", 32'(odd), 32'(sb[0].o));
        chk("even", 32'(even), 32'(!sb[0].o));
        chk("run_hit", 32'(run_hit), 32'(sb[0].h));
      end
      chk("even_cnt", 32'(even_cnt), 32'(m_even));
      chk("odd_cnt", 32'(odd_cnt), 32'(m_odd));
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready && sb.size() > 0) begin
        odd_bits = {odd_bits[30:0], sb[0].o};
        hit_bits = {hit_bits[30:0], sb[0].h};
        void'(sb.pop_front());
        pops++;
      end
      if (clr_cnt) begin
        m_even = 0;
        m_odd = 0;
      end
      if (in_valid && in_ready) begin
        beat_t      b;
        logic [2:0] key;
        logic       all_same;
        b.d = data_in;
        b.o = ref_odd(data_in, mode);
        key = {mode, b.o};
        hist.push_back(key);
        if (hist.size() > RL) void'(hist.pop_front());
        all_same = (hist.size() == RL);
        foreach (hist[k]) if (hist[k] != key) all_same = 1'b0;
        b.h = all_same;
        sb.push_back(b);
        if (b.o) begin
          if (m_odd < CMAX) m_odd++;
        end else begin
          if (m_even < CMAX) m_even++;
        end
      end
    end
  end

  // Present one word and hold it until it is accepted; returns just after the accept edge.
  task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic c);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    data_in = d;
    mode = m;
    clr_cnt = c;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    odd_bits = '0;
    hit_bits = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_even_cnt", 32'(even_cnt), 32'd0);
    chk("reset_odd_cnt", 32'(odd_cnt), 32'd0);
    chk("reset_flags", 32'({even, odd, run_hit}), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset asserted while a beat is pending drops it at once.
    ready_mode = 0;
    @(posedge clk);
    #1;
    send(8'h07, 2'b00, 1'b0);
    chk("pending_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_odd_cnt", 32'(odd_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready_mode = 1;
    @(posedge clk);
    #1;

    // Mode 00 basic beats.
    clear_logs();
    send(8'h04, 2'b00, 1'b0);
    send(8'h07, 2'b00, 1'b0);
    drain();
    chk("m00_odd_seq", odd_bits, 32'b01);
    chk("m00_even_cnt", 32'(even_cnt), 32'd1);
    chk("m00_odd_cnt", 32'(odd_cnt), 32'd1);

    // Same word under different modes, and mode 10 (11 behaves as 00).
    clear_logs();
    send(8'h03, 2'b00, 1'b0);
    send(8'h03, 2'b01, 1'b0);
    send(8'h0C, 2'b10, 1'b0);
    send(8'h06, 2'b10, 1'b0);
    send(8'h03, 2'b11, 1'b0);
    drain();
    chk("modes_odd_seq", odd_bits, 32'b10011);

    // Runs: 2,4,6,8,10,1 then a mode switch restarting the count.
    clear_logs();
    send(8'd2, 2'b00, 1'b0);
    send(8'd4, 2'b00, 1'b0);
    send(8'd6, 2'b00, 1'b0);
    send(8'd8, 2'b00, 1'b0);
    send(8'd10, 2'b00, 1'b0);
    send(8'd1, 2'b00, 1'b0);
    drain();
    chk("run_hit_seq", hit_bits, 32'b000110);
    clear_logs();
    send(8'd4, 2'b00, 1'b0);
    send(8'd8, 2'b00, 1'b0);
    send(8'd12, 2'b00, 1'b0);
    send(8'd16, 2'b10, 1'b0);
    send(8'd20, 2'b10, 1'b0);
    send(8'd24, 2'b10, 1'b0);
    send(8'd28, 2'b10, 1'b0);
    drain();
    chk("run_mode_switch", hit_bits, 32'b0000001);

    // Backpressure: held beat stays, in_ready low, then a 20-word random stream.
    ready_mode = 0;
    @(posedge clk);
    #1;
    p0 = pops;
    send(8'h55, 2'b00, 1'b0);
    in_valid = 1'b1;
    data_in = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_data", 32'(out_data), 32'h55);
    end
    @(posedge clk);
    #1;
    ready_mode = 2;
    send(8'hAA, 2'b00, 1'b0);
    for (int i = 0; i < 18; i++) begin
      send(8'($urandom), 2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    drain();
    chk("bp_word_count", 32'(pops - p0), 32'd20);

    // Saturation with a clear on the first word, then clear with an odd accept.
    send(8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 16; i++) send(8'($urandom) & 8'hFE, 2'b00, 1'b0);
    drain();
    chk("sat_even_cnt", 32'(even_cnt), 32'd15);
    send(8'h01, 2'b00, 1'b1);
    drain();
    chk("clr_odd_cnt", 32'(odd_cnt), 32'd1);
    chk("clr_even_cnt", 32'(even_cnt), 32'd0);

    // Longer random soak with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end
    ready_mode = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
